// File: rtl/conv2d_fx_pkg.sv
// Shared types and helpers for the fixed-point conv2d engine.
// Latency: n/a (package only).
// Backpressure: n/a.
package conv2d_fx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  // Output feature-map edge length for a square input and kernel
  function automatic int out_dim_fn(input int in_dim, input int k,
                                    input int stride, input int pad);
    return (in_dim + 2 * pad - k) / stride + 1;
  endfunction

  // Clamp a signed value to the range of a w-bit signed word
  function automatic logic signed [63:0] sat_fn(input logic signed [63:0] v,
                                                input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Replace negative values with zero
  function automatic logic signed [63:0] relu_fn(input logic signed [63:0] v);
    return (v < 64'sd0) ? 64'sd0 : v;
  endfunction

endpackage

// File: rtl/conv2d_fx_mac.sv
// Fixed-point accumulator: bias load, product accumulate, shift+saturate result register.
// Latency: result register updates on the edge that folds in the last product.
// Backpressure: none; controls are driven by the owning FSM. CONV2D_FX_RELU_EN zeroes negative results.
module conv2d_fx_mac
  import conv2d_fx_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     load_bias_i,
  input  logic                     acc_en_i,
  input  logic                     latch_i,
  input  logic signed [DATA_W-1:0] bias_i,
  input  logic signed [DATA_W-1:0] act_i,
  input  logic signed [DATA_W-1:0] wgt_i,
  output logic        [DATA_W-1:0] res_o
);

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [63:0]         sat_v;
  logic signed [63:0]         fin_v;
  logic        [DATA_W-1:0]   res_q, res_d;

  assign prod = act_i * wgt_i;

  // Next accumulator value: clear, seed with bias in the output's Q format, or add a product
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (load_bias_i) begin
      acc_d = ACC_W'(bias_i) <<< FRAC_W;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Result is taken from acc_d so the word is ready the cycle right after the final product
  always_comb begin
    shifted = acc_d >>> FRAC_W;
    sat_v   = sat_fn(64'(shifted), DATA_W);
`ifdef CONV2D_FX_RELU_EN
    fin_v   = relu_fn(sat_v);
`else
    fin_v   = sat_v;
`endif
    res_d   = latch_i ? DATA_W'(fin_v) : res_q;
  end

  // Accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/conv2d_fx_engine.sv
// Multi-channel strided/padded 2D convolution controller with fixed-point MAC (CONV2D_FX_RELU_EN optional).
// Latency: NUM_IN*K*K+3 cycles per output pixel, constant write spacing.
// Backpressure: none; memories are assumed to answer one cycle after each read strobe.
module conv2d_fx_engine
  import conv2d_fx_pkg::*;
#(
  parameter int NUM_IN  = 1,
  parameter int NUM_OUT = 1,
  parameter int IN_DIM  = 5,
  parameter int K       = 3,
  parameter int STRIDE  = 1,
  parameter int PAD     = 0,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int ACC_W   = 40,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  input  logic [DATA_W-1:0] act_rd_data,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  input  logic [DATA_W-1:0] wgt_rd_data,
  output logic              bias_rd_en,
  output logic [ADDR_W-1:0] bias_rd_addr,
  input  logic [DATA_W-1:0] bias_rd_data,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data
);

  localparam int OUT_DIM = out_dim_fn(IN_DIM, K, STRIDE, PAD);
  localparam int CW      = 16;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] KL  = CW'(K - 1);
  localparam logic [CW-1:0] ICL = CW'(NUM_IN - 1);
  localparam logic [CW-1:0] OCL = CW'(NUM_OUT - 1);
  localparam logic [CW-1:0] ODL = CW'(OUT_DIM - 1);

  state_e state_q, state_d;
  logic [CW-1:0] kx_q, kx_d, ky_q, ky_d, ic_q, ic_d;
  logic [CW-1:0] ox_q, ox_d, oy_q, oy_d, oc_q, oc_d;
  logic act_vld_q, wgt_vld_q, bias_vld_q;
  logic last_tap, last_pix, in_range;
  logic signed [31:0] iy, ix;
  logic [DATA_W-1:0] act_eff, wgt_eff, bias_eff, res;

  assign last_tap = (ic_q == ICL) && (ky_q == KL) && (kx_q == KL);
  assign last_pix = (oc_q == OCL) && (oy_q == ODL) && (ox_q == ODL);

  // Signed input coordinates of the current tap; padded taps fall outside the map
  always_comb begin
    iy       = int'(oy_q) * STRIDE + int'(ky_q) - PAD;
    ix       = int'(ox_q) * STRIDE + int'(kx_q) - PAD;
    in_range = (iy >= 0) && (iy < IN_DIM) && (ix >= 0) && (ix < IN_DIM);
  end

  // FSM next state and strobes
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    bias_rd_en = 1'b0;
    wgt_rd_en  = 1'b0;
    act_rd_en  = 1'b0;
    out_wr_en  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = BIAS;
      BIAS: begin
        busy       = 1'b1;
        bias_rd_en = 1'b1;
        state_d    = MAC;
      end
      MAC: begin
        busy      = 1'b1;
        wgt_rd_en = 1'b1;
        act_rd_en = in_range;
        if (last_tap) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        out_wr_en = 1'b1;
        state_d   = last_pix ? DONE : BIAS;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Loop counters: taps (ic,ky,kx) advance per MAC cycle, pixels (oc,oy,ox) per write
  always_comb begin
    kx_d = kx_q;
    ky_d = ky_q;
    ic_d = ic_q;
    ox_d = ox_q;
    oy_d = oy_q;
    oc_d = oc_q;
    if (state_q == IDLE) begin
      kx_d = '0;
      ky_d = '0;
      ic_d = '0;
      ox_d = '0;
      oy_d = '0;
      oc_d = '0;
    end else if (state_q == MAC) begin
      if (kx_q == KL) begin
        kx_d = '0;
        if (ky_q == KL) begin
          ky_d = '0;
          ic_d = (ic_q == ICL) ? '0 : ic_q + ONE;
        end else begin
          ky_d = ky_q + ONE;
        end
      end else begin
        kx_d = kx_q + ONE;
      end
    end else if (state_q == WRITE) begin
      if (ox_q == ODL) begin
        ox_d = '0;
        if (oy_q == ODL) begin
          oy_d = '0;
          oc_d = (oc_q == OCL) ? '0 : oc_q + ONE;
        end else begin
          oy_d = oy_q + ONE;
        end
      end else begin
        ox_d = ox_q + ONE;
      end
    end
  end

  // State, counters and read-data valid flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      kx_q       <= '0;
      ky_q       <= '0;
      ic_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      oc_q       <= '0;
      act_vld_q  <= 1'b0;
      wgt_vld_q  <= 1'b0;
      bias_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ic_q       <= ic_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      oc_q       <= oc_d;
      act_vld_q  <= act_rd_en;
      wgt_vld_q  <= wgt_rd_en;
      bias_vld_q <= bias_rd_en;
    end
  end

  // Addresses are held at zero whenever their strobe is low
  assign act_rd_addr  = act_rd_en  ? ADDR_W'((int'(ic_q) * IN_DIM + iy) * IN_DIM + ix) : '0;
  assign wgt_rd_addr  = wgt_rd_en  ?
      ADDR_W'(((int'(oc_q) * NUM_IN + int'(ic_q)) * K + int'(ky_q)) * K + int'(kx_q)) : '0;
  assign bias_rd_addr = bias_rd_en ? ADDR_W'(oc_q) : '0;
  assign out_wr_addr  = out_wr_en  ?
      ADDR_W'((int'(oc_q) * OUT_DIM + int'(oy_q)) * OUT_DIM + int'(ox_q)) : '0;
  assign out_wr_data  = out_wr_en  ? res : '0;

  // Read data only counts in the cycle after its strobe; padded taps contribute zero
  assign act_eff  = act_vld_q  ? act_rd_data  : '0;
  assign wgt_eff  = wgt_vld_q  ? wgt_rd_data  : '0;
  assign bias_eff = bias_vld_q ? bias_rd_data : '0;

  conv2d_fx_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (state_q == IDLE),
    .load_bias_i (bias_vld_q),
    .acc_en_i    (wgt_vld_q),
    .latch_i     (state_q == DRAIN),
    .bias_i      (bias_eff),
    .act_i       (act_eff),
    .wgt_i       (wgt_eff),
    .res_o       (res)
  );

endmodule

// File: tb/tb_conv2d_fx_engine.sv
// Self-checking bench: 2 in / 2 out channels, 5x5 input, 3x3 kernel, stride 2, pad 1.
// Latency: checks per-pixel spacing and total busy cycles against the layer geometry.
// Backpressure: n/a; memories answer one cycle after each strobe, garbage otherwise.
module tb_conv2d_fx_engine;
  localparam int NI = 2, NO = 2, ID = 5, KK = 3, ST = 2, PD = 1, DW = 16, FW = 8;
  localparam int OD      = (ID + 2 * PD - KK) / ST + 1;
  localparam int NPIX    = NO * OD * OD;
  localparam int PIX_CYC = NI * KK * KK + 3;
  localparam int NACT    = NI * ID * ID;
  localparam int NWGT    = NO * NI * KK * KK;

  logic clk = 0, rst_n = 0, start = 0;
  logic busy, done, act_rd_en, wgt_rd_en, bias_rd_en, out_wr_en;
  logic [15:0] act_rd_addr, wgt_rd_addr, bias_rd_addr, out_wr_addr, out_wr_data;
  logic [15:0] act_rd_data = 0, wgt_rd_data = 0, bias_rd_data = 0;

  conv2d_fx_engine #(
    .NUM_IN(NI), .NUM_OUT(NO), .IN_DIM(ID), .K(KK), .STRIDE(ST), .PAD(PD),
    .DATA_W(DW), .FRAC_W(FW), .ACC_W(40), .ADDR_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
  );

  always #5 clk = ~clk;

  logic [15:0] act_mem [NACT];
  logic [15:0] wgt_mem [NWGT];
  logic [15:0] bias_mem[NO];
  logic [15:0] got     [NPIX];

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t expq[$];

  int checks = 0, errors = 0;
  int cyc = 0, busy_cnt = 0, done_cnt = 0, rd_cnt = 0, exp_reads = 0, last_wr = -1;

  task automatic chk(input string nm, input longint got_v, input longint exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got_v, exp_v);
    end
  endtask

  // Reference: direct convolution sum for one output pixel
  function automatic logic [15:0] model_px(input int oc, input int oy, input int ox);
    longint acc, a, w;
    int iy, ix;
    acc = longint'($signed(bias_mem[oc])) * (64'sd1 <<< FW);
    for (int ic = 0; ic < NI; ic++)
      for (int ky = 0; ky < KK; ky++)
        for (int kx = 0; kx < KK; kx++) begin
          iy = oy * ST + ky - PD;
          ix = ox * ST + kx - PD;
          if (iy >= 0 && iy < ID && ix >= 0 && ix < ID)
            a = longint'($signed(act_mem[(ic * ID + iy) * ID + ix]));
          else
            a = 0;
          w = longint'($signed(wgt_mem[((oc * NI + ic) * KK + ky) * KK + kx]));
          acc += a * w;
        end
    acc = acc >>> FW;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`ifdef CONV2D_FX_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return 16'(acc);
  endfunction

  task automatic build_expect();
    int iy, ix;
    expq.delete();
    exp_reads = 0;
    for (int oc = 0; oc < NO; oc++)
      for (int oy = 0; oy < OD; oy++)
        for (int ox = 0; ox < OD; ox++) begin
          expq.push_back('{addr: 16'((oc * OD + oy) * OD + ox), data: model_px(oc, oy, ox)});
          for (int ic = 0; ic < NI; ic++)
            for (int ky = 0; ky < KK; ky++)
              for (int kx = 0; kx < KK; kx++) begin
                iy = oy * ST + ky - PD;
                ix = ox * ST + kx - PD;
                if (iy >= 0 && iy < ID && ix >= 0 && ix < ID) exp_reads++;
              end
        end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < NACT; i++)
      case (mode)
        0: act_mem[i] = 16'd256;
        1: act_mem[i] = 16'($urandom_range(0, 4095) - 2048);
        2: act_mem[i] = 16'($urandom);
        3: act_mem[i] = 16'h7FFF;
        default: act_mem[i] = 16'h8000;
      endcase
    for (int i = 0; i < NWGT; i++)
      case (mode)
        0: wgt_mem[i] = 16'd256;
        1: wgt_mem[i] = 16'($urandom_range(0, 1023) - 512);
        2: wgt_mem[i] = 16'($urandom);
        default: wgt_mem[i] = 16'h7FFF;
      endcase
    for (int i = 0; i < NO; i++)
      case (mode)
        0: bias_mem[i] = 16'd256;
        1: bias_mem[i] = 16'($urandom_range(0, 4095) - 2048);
        2: bias_mem[i] = 16'($urandom);
        default: bias_mem[i] = 16'd0;
      endcase
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic run_layer(input string nm);
    int t;
    build_expect();
    busy_cnt = 0; done_cnt = 0; rd_cnt = 0; last_wr = -1;
    start_pulse();
    // a start while busy must not disturb the run
    repeat (40) @(negedge clk);
    start_pulse();
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_timeout"}, longint'(t < 3000), 1);
    repeat (3) @(negedge clk);
    chk({nm, "_missing_writes"}, expq.size(), 0);
    chk({nm, "_busy_cycles"}, busy_cnt, NPIX * PIX_CYC);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_act_reads"}, rd_cnt, exp_reads);
    chk({nm, "_idle_busy"}, {busy, done}, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_strobes"}, {busy, done, act_rd_en, wgt_rd_en, bias_rd_en, out_wr_en}, 0);
    chk({nm, "_rd_addrs"}, {act_rd_addr, wgt_rd_addr, bias_rd_addr}, 0);
    chk({nm, "_wr_addr_data"}, {out_wr_addr, out_wr_data}, 0);
  endtask

  initial begin
    exp_t e;
    fork
      // memories: one-cycle read latency, random garbage when not strobed
      forever begin
        logic ap, wp, bp;
        logic [15:0] aa, wa, ba;
        @(negedge clk);
        ap = act_rd_en; aa = act_rd_addr;
        wp = wgt_rd_en; wa = wgt_rd_addr;
        bp = bias_rd_en; ba = bias_rd_addr;
        @(posedge clk);
        #1;
        act_rd_data  = (ap && aa < NACT) ? act_mem[aa] : 16'($urandom);
        wgt_rd_data  = (wp && wa < NWGT) ? wgt_mem[wa] : 16'($urandom);
        bias_rd_data = (bp && ba < NO)   ? bias_mem[ba] : 16'($urandom);
      end
      forever begin
        @(posedge clk);
        cyc++;
      end
      // output monitor
      forever begin
        @(negedge clk);
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (act_rd_en) begin
          rd_cnt++;
          chk("act_addr_range", longint'(act_rd_addr < NACT), 1);
        end
        if (wgt_rd_en) chk("wgt_addr_range", longint'(wgt_rd_addr < NWGT), 1);
        if (out_wr_en) begin
          if (expq.size() == 0) begin
            chk("unexpected_write", out_wr_addr, -1);
          end else begin
            e = expq.pop_front();
            chk("out_addr", out_wr_addr, e.addr);
            chk("out_data", $signed(out_wr_data), $signed(e.data));
            if (out_wr_addr < NPIX) got[out_wr_addr] = out_wr_data;
          end
          if (last_wr >= 0) chk("write_spacing", cyc - last_wr, PIX_CYC);
          last_wr = cyc;
        end
      end
    join_none

    rst_n = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1;
    repeat (2) @(negedge clk);

    // all ones with bias 1.0: corner 9, edge 13, centre 19 (Q8)
    fill(0);
    run_layer("ones");
    chk("ones_corner", got[0], 2304);
    chk("ones_edge", got[1], 3328);
    chk("ones_centre", got[4], 4864);
    chk("ones_far_corner", got[8], 2304);
    chk("ones_oc1_centre", got[13], 4864);

    fill(1);
    run_layer("rand_small");
    fill(2);
    run_layer("rand_full");

    fill(3);
    run_layer("sat_pos");
    chk("sat_pos_centre", got[4], 16'h7FFF);
    fill(4);
    run_layer("sat_neg");
`ifdef CONV2D_FX_RELU_EN
    chk("sat_neg_centre", got[4], 0);
`else
    chk("sat_neg_centre", got[4], 16'h8000);
`endif

    // abort mid-MAC, then rerun the same data
    fill(1);
    build_expect();
    busy_cnt = 0; done_cnt = 0; last_wr = -1;
    start_pulse();
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1 chk_all_zero("abort");
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_write", expq.size(), NPIX);
    rst_n = 1;
    repeat (2) @(negedge clk);
    run_layer("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
